// File: rtl/key_rate_sel_if.sv
// Key inputs and rate outputs of key_rate_sel, bundled for the tick generator.
// master drives the keys; slave is the rate-select block itself.
interface key_rate_sel_if;
    logic [1:0] key_n;
    logic       rate_tick;
    logic [1:0] rate_sel;
    logic       run;

    modport master (output key_n, input rate_tick, rate_sel, run);
    modport slave  (input key_n, output rate_tick, rate_sel, run);
endinterface

// File: rtl/key_rate_sel.sv
// Two debounced push buttons: RATE cycles through four tick rates, PAUSE gates ticks.
// key_deb synchronizes one active-low key, debounces it and flags the 1->0 press.
module key_deb #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);
    localparam int            CW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync;
    logic          stable, stable_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync     <= 2'b11;
            stable   <= 1'b1;
            stable_d <= 1'b1;
            cnt      <= '0;
        end else begin
            sync     <= {sync[0], key_n};
            stable_d <= stable;
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Falling edge of the accepted level only; release produces nothing.
    assign press = stable_d & ~stable;
endmodule

module key_rate_sel #(
    parameter int DEB_CYCLES = 1000000,
    parameter int TC0        = 24999999,
    parameter int TC1        = 12499999,
    parameter int TC2        = 6249999,
    parameter int TC3        = 3124999
) (
    input  logic           clk,
    input  logic           rst,
    key_rate_sel_if.slave  bus
);
    localparam int NUM_KEYS = 2;
    localparam int K_RATE   = 0;
    localparam int K_PAUSE  = 1;

    logic [NUM_KEYS-1:0] key_n;
    logic [NUM_KEYS-1:0] press;
    logic [24:0]         div_cnt;
    logic [24:0]         tc;
    logic [1:0]          rate_sel;
    logic                run, run_nxt, tick;

    assign key_n = bus.key_n;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .rst   (rst),
            .key_n (key_n[k]),
            .press (press[k])
        );
    end

    always_comb begin
        tc = 25'(TC0);
        case (rate_sel)
            2'd1:    tc = 25'(TC1);
            2'd2:    tc = 25'(TC2);
            2'd3:    tc = 25'(TC3);
            default: tc = 25'(TC0);
        endcase
    end

    // Divider follows the run level being latched this edge, so a pause
    // freezes the count exactly where the press found it and a resume
    // starts counting on the same edge that sets run.
    assign run_nxt = run ^ press[K_PAUSE];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            tick     <= 1'b0;
            rate_sel <= 2'd0;
            run      <= 1'b1;
        end else begin
            if (press[K_RATE])  rate_sel <= rate_sel + 2'd1;
            if (press[K_PAUSE]) run      <= ~run;
            if (press[K_RATE]) begin
                div_cnt <= '0;
                tick    <= 1'b0;
            end else if (run_nxt && div_cnt == tc) begin
                div_cnt <= '0;
                tick    <= 1'b1;
            end else begin
                tick <= 1'b0;
                if (run_nxt) div_cnt <= div_cnt + 25'd1;
            end
        end
    end

    assign bus.rate_tick = tick;
    assign bus.rate_sel  = rate_sel;
    assign bus.run       = run;
endmodule

// File: tb/tb_key_rate_sel.sv
// Directed bench for key_rate_sel with short debounce and small terminal counts.
// Outputs are sampled on the falling clock edge; keys change on the falling edge.
module tb_key_rate_sel;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   failed = 0;
    int   tick_cnt = 0;
    int   adj = 0;
    logic prev_tick = 1'b0;

    key_rate_sel_if bus();

    key_rate_sel #(
        .DEB_CYCLES(4), .TC0(15), .TC1(7), .TC2(3), .TC3(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            prev_tick = 1'b0;
        end else begin
            if (bus.rate_tick && prev_tick) adj++;
            if (bus.rate_tick) tick_cnt++;
            prev_tick = bus.rate_tick;
        end
    end

    typedef struct {
        logic [1:0] key;
        int         ncyc;
        logic [1:0] exp_rate;
        logic       exp_run;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input int act, input int req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick(output int n, input int lim);
        n = -1;
        for (int i = 1; i <= lim; i++) begin
            @(negedge clk);
            if (bus.rate_tick) begin
                n = i;
                break;
            end
        end
    endtask

    // Drive key pattern k and count cycles until rate_sel or run changes.
    task automatic press(input logic [1:0] k, output int n);
        logic [1:0] r0;
        logic       u0;
        r0 = bus.rate_sel;
        u0 = bus.run;
        bus.key_n = k;
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus.rate_sel !== r0 || bus.run !== u0) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic release_keys();
        bus.key_n = 2'b11;
        step(10);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.key_n = 2'b11;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        int n, t0;
        bus.key_n = 2'b11;

        vecs[0]  = '{2'b11, 10, 2'd0, 1'b1};
        vecs[1]  = '{2'b10,  3, 2'd0, 1'b1};
        vecs[2]  = '{2'b11, 12, 2'd0, 1'b1};
        vecs[3]  = '{2'b10, 20, 2'd1, 1'b1};
        vecs[4]  = '{2'b11, 10, 2'd1, 1'b1};
        vecs[5]  = '{2'b10, 10, 2'd2, 1'b1};
        vecs[6]  = '{2'b11, 10, 2'd2, 1'b1};
        vecs[7]  = '{2'b10, 10, 2'd3, 1'b1};
        vecs[8]  = '{2'b11, 10, 2'd3, 1'b1};
        vecs[9]  = '{2'b10, 10, 2'd0, 1'b1};
        vecs[10] = '{2'b11, 10, 2'd0, 1'b1};
        vecs[11] = '{2'b01, 10, 2'd0, 1'b0};
        vecs[12] = '{2'b11, 10, 2'd0, 1'b0};
        vecs[13] = '{2'b00, 10, 2'd1, 1'b1};
        vecs[14] = '{2'b11, 10, 2'd1, 1'b1};

        // Reset state and idle tick period
        step(2);
        chk("reset rate_sel", int'(bus.rate_sel), 0);
        chk("reset run", int'(bus.run), 1);
        chk("reset tick", int'(bus.rate_tick), 0);
        rst = 1'b0;
        wait_tick(n, 40);
        chk("first tick after reset", n, 16);
        wait_tick(n, 40);
        chk("idle tick period", n, 16);
        chk("idle rate_sel", int'(bus.rate_sel), 0);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            bus.key_n = vecs[i].key;
            step(vecs[i].ncyc);
            chk($sformatf("vec%0d rate_sel", i), int'(bus.rate_sel), int'(vecs[i].exp_rate));
            chk($sformatf("vec%0d run", i), int'(bus.run), int'(vecs[i].exp_run));
        end

        // Held RATE key: one change, then 8-cycle ticks
        do_reset();
        press(2'b10, n);
        chk("rate press latency", n, 7);
        chk("rate_sel after hold", int'(bus.rate_sel), 1);
        wait_tick(n, 40);
        chk("first tick rate1", n, 8);
        wait_tick(n, 40);
        chk("tick period rate1", n, 8);
        step(5);
        chk("rate_sel still 1 after 20 low", int'(bus.rate_sel), 1);
        release_keys();

        // Walk to rate 3, then wrap
        press(2'b10, n);
        chk("rate_sel step 2", int'(bus.rate_sel), 2);
        release_keys();
        press(2'b10, n);
        chk("rate_sel step 3", int'(bus.rate_sel), 3);
        wait_tick(n, 20);
        chk("first tick rate3", n, 2);
        wait_tick(n, 20);
        chk("tick period rate3 a", n, 2);
        wait_tick(n, 20);
        chk("tick period rate3 b", n, 2);
        release_keys();
        press(2'b10, n);
        chk("rate_sel wrap", int'(bus.rate_sel), 0);
        release_keys();

        // Short glitch is ignored
        bus.key_n = 2'b10;
        step(3);
        bus.key_n = 2'b11;
        step(15);
        chk("glitch rate_sel", int'(bus.rate_sel), 0);

        // Pause with div_cnt=5, resume: 10 cycles to next tick
        wait_tick(n, 40);
        step(15);
        press(2'b01, n);
        chk("pause latency", n, 7);
        chk("run after pause", int'(bus.run), 0);
        t0 = tick_cnt;
        step(10);
        release_keys();
        step(20);
        chk("no ticks while paused", tick_cnt - t0, 0);
        press(2'b01, n);
        chk("run after resume", int'(bus.run), 1);
        wait_tick(n, 40);
        chk("tick after resume", n, 10);
        wait_tick(n, 40);
        chk("tick period after resume", n, 16);
        release_keys();

        // Both keys in one cycle
        press(2'b00, n);
        chk("both latency", n, 7);
        chk("both rate_sel", int'(bus.rate_sel), 1);
        chk("both run", int'(bus.run), 0);
        release_keys();

        // Reset in the middle of a debounce
        bus.key_n = 2'b10;
        step(3);
        rst = 1'b1;
        bus.key_n = 2'b11;
        #1;
        chk("async reset rate_sel", int'(bus.rate_sel), 0);
        chk("async reset run", int'(bus.run), 1);
        chk("async reset tick", int'(bus.rate_tick), 0);
        step(2);
        rst = 1'b0;
        wait_tick(n, 40);
        chk("first tick after mid reset", n, 16);
        chk("rate_sel after mid reset", int'(bus.rate_sel), 0);
        chk("run after mid reset", int'(bus.run), 1);

        chk("adjacent ticks", adj, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/key_rate_sel.md
KEY_RATE_SEL -- requirements
Module: key_rate_sel

Interface
REQ-001 Parameter DEB_CYCLES, default 1000000, is the number of consecutive disagreeing cycles required to accept a key level (20 ms at 50 MHz).
REQ-002 Parameter TC0, default 24999999, is the divider terminal count for rate_sel=0.
REQ-003 Parameter TC1, default 12499999, is the divider terminal count for rate_sel=1.
REQ-004 Parameter TC2, default 6249999, is the divider terminal count for rate_sel=2.
REQ-005 Parameter TC3, default 3124999, is the divider terminal count for rate_sel=3.
REQ-006 Port clk: input, 1 bit, the single system clock; all logic is clocked on its rising edge.
REQ-007 Port rst: input, 1 bit, asynchronous active-high reset.
REQ-008 Port key_n: input, 2 bits, asynchronous active-low buttons; bit 0 is RATE and bit 1 is PAUSE.
REQ-009 Port rate_tick: output, 1 bit, a registered one-cycle pulse at the selected rate, consumed by the downstream LED toggle stage.
REQ-010 Port rate_sel: output, 2 bits, the registered current rate index.
REQ-011 Port run: output, 1 bit, registered; 1 means ticks are being generated.

Function
REQ-012 Each key_n bit SHALL pass through a 2-FF synchronizer; synchronizer flops SHALL reset to 1.
REQ-013 Each key SHALL have an independent debouncer holding a stable level (reset 1) and a counter sized for DEB_CYCLES-1.
REQ-014 Debouncer, synced level equals stable level: counter cleared.
REQ-015 Debouncer, synced level differs from stable level: counter increments; when counter equals DEB_CYCLES-1, stable takes the synced level and the counter clears.
REQ-016 A stable 1->0 transition SHALL produce an internal press event one cycle wide; 0->1 transitions produce no event.
REQ-017 RATE press: rate_sel SHALL increment modulo 4 (3 wraps to 0) on the clock edge after the stable transition.
REQ-018 PAUSE press: run SHALL toggle on the clock edge after the stable transition.
REQ-019 Simultaneous RATE and PAUSE press events in one cycle: both actions SHALL apply in that same cycle.
REQ-020 Divider: a 25-bit div_cnt; the terminal count tc is selected by rate_sel from TC0..TC3.
REQ-021 run=1 and div_cnt==tc: div_cnt becomes 0 and rate_tick is 1 next cycle; otherwise div_cnt increments and rate_tick is 0. The tick period is therefore tc+1 cycles.
REQ-022 run=0: div_cnt SHALL hold and rate_tick SHALL be 0; counting resumes from the held value when run returns to 1.
REQ-023 A RATE press SHALL clear div_cnt to 0 in the same cycle as rate_sel updates, with no tick that cycle, so the first tick after a change comes tc_new+1 cycles later.
REQ-024 rate_tick SHALL never be high on two consecutive cycles for any TC value of 1 or more.
REQ-025 A key held low indefinitely SHALL generate exactly one press event; a glitch shorter than DEB_CYCLES cycles SHALL generate none.

Reset
REQ-026 Asserting rst SHALL immediately force: synchronizers and stable levels to 1, debounce counters to 0, div_cnt to 0, rate_tick=0, rate_sel=0, run=1.
REQ-027 Reset asserted mid-debounce or mid-count SHALL discard all partial progress; no press event or tick SHALL be emitted on the first edge after deassertion.
REQ-028 After deassertion, the first rate_tick SHALL occur TC0+1 cycles later.

Verification (parameters DEB_CYCLES=4, TC0=15, TC1=7, TC2=3, TC3=1)
REQ-029 Release rst with keys idle: rate_tick pulses every 16 cycles, rate_sel=0, run=1.
REQ-030 Hold key_n[0] low for 20 cycles: rate_sel goes 0->1 exactly once, ticks then occur every 8 cycles, first tick 8 cycles after the change.
REQ-031 Four RATE presses: rate_sel sequence 1,2,3,0; while rate_sel=3, ticks occur every 2 cycles and are never adjacent.
REQ-032 Pulse key_n[0] low for 3 cycles: no change to rate_sel.
REQ-033 PAUSE press mid-count at div_cnt=5: ticks stop and div_cnt holds at 5; a second PAUSE press resumes, with the next tick 10 cycles after resume (rate_sel=0).
REQ-034 Both keys pressed in the same cycle: rate_sel increments and run toggles together; rst asserted mid-debounce leaves rate_sel=0, run=1.
